// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts spike_in rising edges over fixed windows with a
// valid/ready result handoff, and measures the interval between recent edges.
module spike_rate_monitor #(
    parameter logic [23:0] WINDOW = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spike_in,
    input  logic        enable,
    input  logic        ready,
    output logic [7:0]  count_out,
    output logic        valid,
    output logic        overrun,
    output logic [15:0] isi_out
);

    localparam int unsigned T_W   = 24;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ISI_W = 16;

    localparam logic [T_W-1:0]   T_LAST  = WINDOW - T_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               prev_q, prev_d;
    logic [ISI_W-1:0]   gap_q, gap_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic [ISI_W-1:0]   isi_q, isi_d;

    logic               edge_c;
    logic               win_end_c;
    logic [CNT_W-1:0]   acc_inc_c;
    logic [CNT_W-1:0]   result_c;
    logic [ISI_W-1:0]   gap_inc_c;

    // Edge detect, saturating increments and window-end decode
    always_comb begin
        edge_c    = spike_in & ~prev_q;
        acc_inc_c = (acc_q == CNT_MAX) ? acc_q : acc_q + CNT_W'(1);
        result_c  = edge_c ? acc_inc_c : acc_q;
        gap_inc_c = (gap_q == ISI_MAX) ? gap_q : gap_q + ISI_W'(1);
        win_end_c = (state_q == COUNT) && enable && (t_q == T_LAST);
    end

    // Window FSM plus result handoff and ISI tracking
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        acc_d     = acc_q;
        prev_d    = spike_in;
        gap_d     = gap_inc_c;
        armed_d   = armed_q;
        count_d   = count_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        isi_d     = isi_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COUNT;
                    t_d     = '0;
                    acc_d   = '0;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                    t_d     = '0;
                    acc_d   = '0;
                end else if (win_end_c) begin
                    t_d   = '0;
                    acc_d = '0;
                end else begin
                    t_d   = t_q + T_W'(1);
                    acc_d = result_c;
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
                acc_d   = '0;
            end
        endcase

        // A finished window lands only if the slot is free or being drained now
        if (win_end_c) begin
            if (!valid_q || ready) begin
                count_d = result_c;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (edge_c) begin
            gap_d   = '0;
            armed_d = 1'b1;
            if (armed_q) begin
                isi_d = gap_inc_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            t_q       <= '0;
            acc_q     <= '0;
            prev_q    <= 1'b0;
            gap_q     <= '0;
            armed_q   <= 1'b0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            isi_q     <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            gap_q     <= gap_d;
            armed_q   <= armed_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            isi_q     <= isi_d;
        end
    end

    assign count_out = count_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign isi_out   = isi_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Scoreboard bench for spike_rate_monitor: three instances (WINDOW 8, 300, 600),
// directed spike patterns with hand-computed counts, intervals and flags.
module tb_spike_rate_monitor;

    typedef struct packed {
        int val;
        int stp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        spike_a, enable_a, ready_a;
    logic [7:0]  count_a;
    logic        valid_a, overrun_a;
    logic [15:0] isi_a;

    logic        spike_b, enable_b, ready_b;
    logic [7:0]  count_b, count_c;
    logic        valid_b, overrun_b, valid_c, overrun_c;
    logic [15:0] isi_b, isi_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_tests = 0;
    int n_fail  = 0;
    int stepno  = 0;
    int v0, c0;

    spike_rate_monitor #(.WINDOW(24'd8)) u_a (
        .clk(clk), .reset(reset), .spike_in(spike_a), .enable(enable_a), .ready(ready_a),
        .count_out(count_a), .valid(valid_a), .overrun(overrun_a), .isi_out(isi_a)
    );

    spike_rate_monitor #(.WINDOW(24'd300)) u_b (
        .clk(clk), .reset(reset), .spike_in(spike_b), .enable(enable_b), .ready(ready_b),
        .count_out(count_b), .valid(valid_b), .overrun(overrun_b), .isi_out(isi_b)
    );

    spike_rate_monitor #(.WINDOW(24'd600)) u_c (
        .clk(clk), .reset(reset), .spike_in(spike_b), .enable(enable_b), .ready(ready_b),
        .count_out(count_c), .valid(valid_c), .overrun(overrun_c), .isi_out(isi_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
        stepno++;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (step %0d)", name, act, req, stepno);
        end
    endtask

    task automatic sb_check(input string name, input bit have, input exp_t e, input int act);
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: unexpected result %0d, expected none (step %0d)", name, act, stepno);
        end else begin
            if (act != e.val) begin
                n_fail++;
                $display("FAIL %s: count %0d, expected %0d (step %0d)", name, act, e.val, stepno);
            end
            if (e.stp >= 0) begin
                n_tests++;
                if (stepno != e.stp) begin
                    n_fail++;
                    $display("FAIL %s_latency: result at step %0d, expected step %0d", name, stepno, e.stp);
                end
            end
        end
    endtask

    // Pops an expectation whenever a result is handed over (valid && ready)
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_a && ready_a) begin
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    sb_check("sb_a", 1'b1, e, int'(count_a));
                end else begin
                    e = '{val: 0, stp: -1};
                    sb_check("sb_a", 1'b0, e, int'(count_a));
                end
            end
            if (valid_b && ready_b) begin
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    sb_check("sb_b", 1'b1, e, int'(count_b));
                end else begin
                    e = '{val: 0, stp: -1};
                    sb_check("sb_b", 1'b0, e, int'(count_b));
                end
            end
            if (valid_c && ready_b) begin
                if (q_c.size() > 0) begin
                    e = q_c.pop_front();
                    sb_check("sb_c", 1'b1, e, int'(count_c));
                end else begin
                    e = '{val: 0, stp: -1};
                    sb_check("sb_c", 1'b0, e, int'(count_c));
                end
            end
        end
    endtask

    // One 8-cycle window on instance A; bit i of pat/rmask drives step i
    task automatic run_window(input logic [7:0] pat, input logic [7:0] rmask,
                              input int exp_val, input bit push, input bit lat);
        exp_t e;
        if (push) begin
            e.val = exp_val;
            e.stp = lat ? stepno + 8 : -1;
            q_a.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            spike_a  = pat[i];
            enable_a = 1'b1;
            ready_a  = rmask[i];
            step();
            if (i == 0) begin
                v0 = int'(valid_a);
                c0 = int'(count_a);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        spike_a  = 1'b0; enable_a = 1'b0; ready_a = 1'b1;
        spike_b  = 1'b0; enable_b = 1'b0; ready_b = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) step();
        check("rst_count", int'(count_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_overrun", int'(overrun_a), 0);
        check("rst_isi", int'(isi_a), 0);
        check("rst_valid_c", int'(valid_c), 0);

        reset = 1'b0;
        step();
        enable_a = 1'b1;
        step();

        // Three single-cycle spikes
        run_window(8'b0010_1010, 8'hFF, 3, 1'b1, 1'b1);
        check("isi_two", int'(isi_a), 2);
        // Spike held high five cycles counts once
        run_window(8'b0011_1110, 8'hFF, 1, 1'b1, 1'b1);
        check("valid_clear", v0, 0);
        check("count_held", c0, 3);
        // Edges on the first and the last cycle of the window
        run_window(8'b1000_0001, 8'hFF, 2, 1'b1, 1'b1);

        // Consumer stalls across two window ends
        run_window(8'b0101_0100, 8'b0000_0001, 3, 1'b1, 1'b0);
        check("stall_valid", int'(valid_a), 1);
        check("stall_overrun0", int'(overrun_a), 0);
        run_window(8'b0000_0110, 8'h00, 1, 1'b0, 1'b0);
        check("drop_overrun", int'(overrun_a), 1);
        check("drop_count_kept", int'(count_a), 3);
        run_window(8'b0101_0101, 8'b1000_0000, 4, 1'b1, 1'b1);
        check("reload_valid", int'(valid_a), 1);
        check("reload_count", int'(count_a), 4);

        // Enable dropped at t=4 with two edges counted
        for (int i = 0; i < 4; i++) begin
            spike_a  = (i % 2 == 0) ? 1'b1 : 1'b0;
            enable_a = 1'b1;
            ready_a  = 1'b1;
            step();
        end
        enable_a = 1'b0; spike_a = 1'b0; step();
        spike_a = 1'b1; step();
        spike_a = 1'b0; step();
        check("abort_no_result", int'(valid_a), 0);
        check("abort_count_held", int'(count_a), 4);
        enable_a = 1'b1; spike_a = 1'b1; step();
        run_window(8'b0000_0010, 8'hFF, 1, 1'b1, 1'b1);

        // Partial window then asynchronous reset mid-cycle
        spike_a = 1'b1; step();
        spike_a = 1'b0; step();
        check("pre_rst_isi", int'(isi_a), 7);
        check("pre_rst_overrun", int'(overrun_a), 1);
        check("pre_rst_count", int'(count_a), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_count", int'(count_a), 0);
        check("mid_rst_valid", int'(valid_a), 0);
        check("mid_rst_overrun", int'(overrun_a), 0);
        check("mid_rst_isi", int'(isi_a), 0);
        enable_a = 1'b0;
        spike_a  = 1'b0;
        step();
        reset = 1'b0;

        // Inter-spike interval: edges 25 cycles apart, then 70000 apart
        for (int k = 1; k <= 35; k++) begin
            spike_a = (k == 10 || k == 35) ? 1'b1 : 1'b0;
            step();
            if (k == 10) check("isi_first_arms", int'(isi_a), 0);
        end
        check("isi_25", int'(isi_a), 25);
        for (int k = 36; k <= 70035; k++) begin
            spike_a = (k == 70035) ? 1'b1 : 1'b0;
            step();
        end
        check("isi_sat", int'(isi_a), 65535);
        spike_a = 1'b0;

        // Spike toggling every cycle on the long-window instances
        enable_b = 1'b1;
        spike_b  = 1'b0;
        step();
        q_b.push_back('{val: 150, stp: stepno + 300});
        q_b.push_back('{val: 150, stp: stepno + 600});
        q_c.push_back('{val: 255, stp: stepno + 600});
        for (int i = 0; i < 600; i++) begin
            spike_b = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        enable_b = 1'b0;
        spike_b  = 1'b0;
        repeat (4) step();

        check("isi_b", int'(isi_b), 2);
        check("isi_c", int'(isi_c), 2);
        check("overrun_b", int'(overrun_b), 0);
        check("overrun_c", int'(overrun_c), 0);
        check("sb_a_drained", q_a.size(), 0);
        check("sb_b_drained", q_b.size(), 0);
        check("sb_c_drained", q_c.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
